// File: rtl/ddram_responder.sv
// Burst responder for the cache DDRAM port, backed by a 2^MEMBITS x 64 block RAM; reads return the first beat RD_LATENCY edges after accept.
// Write beats commit at their accept edge; BUSY holds off the master for a whole read and whenever STALL is forced.
module ddram_responder #(
    parameter int ADDRBITS   = 24,
    parameter int MEMBITS    = 12,
    parameter int RD_LATENCY = 4
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                STALL,
    input  logic [ADDRBITS:0]   DDRAM_ADDR,
    input  logic [7:0]          DDRAM_BURSTCNT,
    input  logic                DDRAM_RD,
    input  logic                DDRAM_WE,
    input  logic [63:0]         DDRAM_DIN,
    input  logic [7:0]          DDRAM_BE,
    output logic [63:0]         DDRAM_DOUT,
    output logic                DDRAM_DOUT_READY,
    output logic                DDRAM_BUSY
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRBURST = 2'd1,
        RDWAIT  = 2'd2,
        RDBURST = 2'd3
    } state_t;

    localparam logic [MEMBITS-1:0] IDX_ONE = {{(MEMBITS-1){1'b0}}, 1'b1};
    localparam logic [3:0]         LAT_INIT = 4'(RD_LATENCY - 1);

    state_t             state;
    logic [MEMBITS-1:0] waddr;
    logic [MEMBITS-1:0] raddr;
    logic [7:0]         wleft;
    logic [7:0]         rleft;
    logic [3:0]         lat;

    logic [7:0]         beats;
    logic               wr_en;
    logic [MEMBITS-1:0] wr_idx;
    logic               rd_en;
    logic [63:0]        rd_q;
    logic [63:0]        mem [0:(1<<MEMBITS)-1];
    logic               unused_addr;

    // Upper address bits alias onto the RAM.
    assign unused_addr = ^DDRAM_ADDR[ADDRBITS:MEMBITS];

    assign beats = (DDRAM_BURSTCNT == 8'd0) ? 8'd1 : DDRAM_BURSTCNT;

    always_comb begin
        DDRAM_BUSY = RESET;
        if ((state == IDLE) || (state == WRBURST)) begin
            DDRAM_BUSY = RESET | STALL;
        end else begin
            DDRAM_BUSY = 1'b1;
        end
    end

    always_comb begin
        wr_en  = 1'b0;
        wr_idx = DDRAM_ADDR[MEMBITS-1:0];
        if (DDRAM_WE && !DDRAM_BUSY) begin
            if (state == IDLE) begin
                wr_en = 1'b1;
            end else if (state == WRBURST) begin
                wr_en  = 1'b1;
                wr_idx = waddr;
            end
        end
    end

    // Each RAM read is issued one edge ahead of the beat that presents it.
    always_comb begin
        rd_en = 1'b0;
        if ((state == RDWAIT) && (lat == 4'd1)) begin
            rd_en = 1'b1;
        end else if ((state == RDBURST) && (rleft != 8'd0)) begin
            rd_en = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            for (int b = 0; b < 8; b++) begin
                if (DDRAM_BE[b]) begin
                    mem[wr_idx][8*b +: 8] <= DDRAM_DIN[8*b +: 8];
                end
            end
        end
        if (rd_en) begin
            rd_q <= mem[raddr];
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state            <= IDLE;
            waddr            <= '0;
            raddr            <= '0;
            wleft            <= 8'd0;
            rleft            <= 8'd0;
            lat              <= 4'd0;
            DDRAM_DOUT       <= 64'd0;
            DDRAM_DOUT_READY <= 1'b0;
        end else begin
            DDRAM_DOUT_READY <= 1'b0;
            case (state)
                IDLE: begin
                    if (DDRAM_WE && !STALL) begin
                        // A simultaneous RD is dropped: the write wins.
                        waddr <= DDRAM_ADDR[MEMBITS-1:0] + IDX_ONE;
                        wleft <= beats - 8'd1;
                        if (beats > 8'd1) begin
                            state <= WRBURST;
                        end
                    end else if (DDRAM_RD && !STALL) begin
                        raddr <= DDRAM_ADDR[MEMBITS-1:0];
                        rleft <= beats;
                        lat   <= LAT_INIT;
                        state <= RDWAIT;
                    end
                end
                WRBURST: begin
                    if (DDRAM_WE && !STALL) begin
                        waddr <= waddr + IDX_ONE;
                        wleft <= wleft - 8'd1;
                        if (wleft == 8'd1) begin
                            state <= IDLE;
                        end
                    end
                end
                RDWAIT: begin
                    if (lat == 4'd1) begin
                        raddr <= raddr + IDX_ONE;
                        rleft <= rleft - 8'd1;
                        lat   <= 4'd0;
                        state <= RDBURST;
                    end else begin
                        lat <= lat - 4'd1;
                    end
                end
                RDBURST: begin
                    DDRAM_DOUT_READY <= 1'b1;
                    DDRAM_DOUT       <= rd_q;
                    if (rleft != 8'd0) begin
                        raddr <= raddr + IDX_ONE;
                        rleft <= rleft - 8'd1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddram_responder.sv
// Randomised scoreboard bench for ddram_responder against a flat array memory model.
module tb_ddram_responder;

    localparam int L   = 4;
    localparam int MB  = 12;
    localparam int AB  = 24;
    localparam int MSZ = 1 << MB;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          STALL = 1'b0;
    logic [AB:0]   DDRAM_ADDR = '0;
    logic [7:0]    DDRAM_BURSTCNT = 8'd0;
    logic          DDRAM_RD = 1'b0;
    logic          DDRAM_WE = 1'b0;
    logic [63:0]   DDRAM_DIN = 64'd0;
    logic [7:0]    DDRAM_BE = 8'd0;
    logic [63:0]   DDRAM_DOUT;
    logic          DDRAM_DOUT_READY;
    logic          DDRAM_BUSY;

    ddram_responder #(.ADDRBITS(AB), .MEMBITS(MB), .RD_LATENCY(L)) dut (
        .CLK(CLK), .RESET(RESET), .STALL(STALL),
        .DDRAM_ADDR(DDRAM_ADDR), .DDRAM_BURSTCNT(DDRAM_BURSTCNT),
        .DDRAM_RD(DDRAM_RD), .DDRAM_WE(DDRAM_WE),
        .DDRAM_DIN(DDRAM_DIN), .DDRAM_BE(DDRAM_BE),
        .DDRAM_DOUT(DDRAM_DOUT), .DDRAM_DOUT_READY(DDRAM_DOUT_READY),
        .DDRAM_BUSY(DDRAM_BUSY)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc++;

    typedef struct {
        logic [63:0] dat;
        int          edge_n;
    } beat_t;

    logic [63:0] mm [MSZ];
    beat_t       sbq[$];
    logic [63:0] wdat [256];
    logic [7:0]  wbe  [256];
    int          tests = 0;
    int          fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic int idx_of(input logic [AB:0] a, input int off);
        return (int'(a[MB-1:0]) + off) % MSZ;
    endfunction

    // Monitor: every beat must match the head of the scoreboard, in data and edge.
    beat_t       mb;
    logic [63:0] last_dout = 64'd0;
    bit          have_last = 1'b0;
    always @(negedge CLK) begin
        if (RESET) begin
            last_dout = 64'd0;
            have_last = 1'b1;
        end else if (DDRAM_DOUT_READY) begin
            if (sbq.size() == 0) begin
                chk("spurious_beat", {63'd0, DDRAM_DOUT_READY}, 64'd0);
            end else begin
                mb = sbq.pop_front();
                chk("beat_data", DDRAM_DOUT, mb.dat);
                chk("beat_edge", 64'(cyc), 64'(mb.edge_n));
            end
            last_dout = DDRAM_DOUT;
        end else if (have_last) begin
            chk("dout_hold", DDRAM_DOUT, last_dout);
        end
    end

    // Called just after a negedge with the request already driven.
    task automatic wait_accept(input bit st_en, output int acc);
        int st;
        int t;
        st  = (st_en && $urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0;
        t   = 0;
        acc = -1;
        forever begin
            STALL = (st > 0);
            #1;
            if (!DDRAM_BUSY) begin
                acc = cyc + 1;
                return;
            end
            if (st > 0) st--;
            t++;
            if (t > 400) begin
                tests++;
                fails++;
                $display("FAIL accept_timeout: still busy after %0d cycles, expected accept", t);
                STALL = 1'b0;
                return;
            end
            @(negedge CLK);
        end
    endtask

    task automatic do_read(input logic [AB:0] addr, input logic [7:0] bc, input bit st_en, output int acc);
        int n;
        n = (bc == 8'd0) ? 1 : int'(bc);
        @(negedge CLK);
        DDRAM_RD       = 1'b1;
        DDRAM_WE       = 1'b0;
        DDRAM_ADDR     = addr;
        DDRAM_BURSTCNT = bc;
        DDRAM_DIN      = {$urandom, $urandom};
        DDRAM_BE       = 8'($urandom);
        wait_accept(st_en, acc);
        if (acc >= 0) begin
            for (int i = 0; i < n; i++) begin
                sbq.push_back(beat_t'{dat: mm[idx_of(addr, i)], edge_n: acc + L + i});
            end
        end
        @(posedge CLK);
        #1;
        DDRAM_RD = 1'b0;
    endtask

    // Beats come from wdat/wbe; gap_before inserts one idle cycle ahead of that beat.
    task automatic do_write(input logic [AB:0] addr, input logic [7:0] bc, input int gap_before, input bit st_en);
        int n;
        int acc;
        int ix;
        n = (bc == 8'd0) ? 1 : int'(bc);
        for (int b = 0; b < n; b++) begin
            @(negedge CLK);
            if (b == gap_before) begin
                DDRAM_WE = 1'b0;
                DDRAM_RD = 1'($urandom);
                @(negedge CLK);
            end
            DDRAM_WE       = 1'b1;
            DDRAM_RD       = ($urandom_range(0, 3) == 0);
            DDRAM_DIN      = wdat[b];
            DDRAM_BE       = wbe[b];
            DDRAM_ADDR     = (b == 0) ? addr : 25'($urandom);
            DDRAM_BURSTCNT = (b == 0) ? bc : 8'($urandom);
            wait_accept(st_en, acc);
            if (acc < 0) break;
            ix = idx_of(addr, b);
            for (int k = 0; k < 8; k++) begin
                if (wbe[b][k]) mm[ix][8*k +: 8] = wdat[b][8*k +: 8];
            end
        end
        @(posedge CLK);
        #1;
        DDRAM_WE = 1'b0;
        DDRAM_RD = 1'b0;
    endtask

    function automatic logic [AB:0] alias_addr(input int ix);
        logic [AB:0] a;
        a = 25'($urandom);
        a[MB-1:0] = MB'(ix);
        return a;
    endfunction

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k1;
        int k2;
        int t;
        int r;
        int n;
        logic [7:0] bc;

        // Reset state
        repeat (2) @(negedge CLK);
        #1;
        chk("rst_busy", {63'd0, DDRAM_BUSY}, 64'd1);
        chk("rst_ready", {63'd0, DDRAM_DOUT_READY}, 64'd0);
        chk("rst_dout", DDRAM_DOUT, 64'd0);
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        chk("post_rst_busy", {63'd0, DDRAM_BUSY}, 64'd0);

        // Preload the window 0xFC0..0x03F (wrapping) and the line at 0x100
        for (int b = 0; b < 64; b++) begin wdat[b] = {$urandom, $urandom}; wbe[b] = 8'hFF; end
        do_write(alias_addr(0), 8'd64, -1, 1'b0);
        for (int b = 0; b < 64; b++) begin wdat[b] = {$urandom, $urandom}; wbe[b] = 8'hFF; end
        do_write(alias_addr(12'hFC0), 8'd64, -1, 1'b0);
        for (int b = 0; b < 8; b++) begin wdat[b] = 64'(32'h100 + b); wbe[b] = 8'hFF; end
        do_write(25'h100, 8'd8, -1, 1'b0);

        // Partial write then single read
        wdat[0] = 64'h1122334455667788; wbe[0] = 8'hFF;
        do_write(25'h10, 8'd1, -1, 1'b0);
        wdat[0] = 64'hAAAAAAAAAAAAAAAA; wbe[0] = 8'h0F;
        do_write(25'h10, 8'd1, -1, 1'b0);
        do_read(25'h10, 8'd1, 1'b0, k1);

        // Line read, then a back-to-back read must land exactly N+L edges later
        do_read(25'h100, 8'd8, 1'b0, k1);
        do_read(25'h101, 8'd0, 1'b0, k2);
        chk("line_reaccept_gap", 64'(k2 - k1), 64'(L + 8));

        // Stall with RD pending for 5 cycles
        @(negedge CLK);
        STALL = 1'b1;
        DDRAM_RD = 1'b1;
        DDRAM_ADDR = 25'h105;
        DDRAM_BURSTCNT = 8'd2;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_busy", {63'd0, DDRAM_BUSY}, 64'd1);
            @(negedge CLK);
        end
        STALL = 1'b0;
        #1;
        chk("stall_release_busy", {63'd0, DDRAM_BUSY}, 64'd0);
        k1 = cyc + 1;
        for (int i = 0; i < 2; i++) sbq.push_back(beat_t'{dat: mm[idx_of(25'h105, i)], edge_n: k1 + L + i});
        @(posedge CLK);
        #1;
        DDRAM_RD = 1'b0;

        // Burst write with a gap between beats 2 and 3, then read one past the end
        for (int b = 0; b < 4; b++) begin wdat[b] = {$urandom, $urandom}; wbe[b] = 8'hFF; end
        do_write(25'h20, 8'd4, 2, 1'b0);
        do_read(25'h20, 8'd5, 1'b0, k1);

        // Wrap at the top of the RAM, read and write
        do_read(25'hFFE, 8'd4, 1'b0, k1);
        for (int b = 0; b < 3; b++) begin wdat[b] = {$urandom, $urandom}; wbe[b] = 8'($urandom); end
        do_write(alias_addr(12'hFFF), 8'd3, -1, 1'b0);
        do_read(alias_addr(12'hFFE), 8'd4, 1'b0, k1);

        // Reset after beat 3 of an 8-beat read
        do_read(25'h0, 8'd8, 1'b0, k1);
        t = 0;
        while (cyc < k1 + L + 2 && t < 100) begin @(negedge CLK); t++; end
        #2;
        RESET = 1'b1;
        #1;
        chk("midrst_ready", {63'd0, DDRAM_DOUT_READY}, 64'd0);
        chk("midrst_busy", {63'd0, DDRAM_BUSY}, 64'd1);
        chk("midrst_dout", DDRAM_DOUT, 64'd0);
        sbq.delete();
        repeat (2) @(negedge CLK);
        #1;
        chk("midrst_busy_hold", {63'd0, DDRAM_BUSY}, 64'd1);
        RESET = 1'b0;
        #1;
        chk("midrst_release_busy", {63'd0, DDRAM_BUSY}, 64'd0);
        do_read(25'h0, 8'd8, 1'b0, k1);

        // Randomised traffic inside the preloaded wrapping window
        for (int op = 0; op < 250; op++) begin
            n  = $urandom_range(0, 8);
            bc = 8'(n);
            r  = $urandom_range(0, 128 - ((n == 0) ? 1 : n));
            if ($urandom_range(0, 1) == 0) begin
                do_read(alias_addr((12'hFC0 + r) % MSZ), bc, 1'b1, k1);
            end else begin
                for (int b = 0; b < 8; b++) begin
                    wdat[b] = {$urandom, $urandom};
                    wbe[b]  = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
                end
                do_write(alias_addr((12'hFC0 + r) % MSZ), bc,
                         ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : -1, 1'b1);
            end
        end

        t = 0;
        while (sbq.size() != 0 && t < 200) begin @(negedge CLK); t++; end
        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ddram_responder.md
# ddram_responder

Avalon-style burst responder for the 64-bit DDRAM port driven by the ao486 L2 cache. It accepts single and burst read/write commands and serves them from an on-chip 64-bit block RAM with a fixed read latency. `BUSY` back-pressure can be forced from outside. It is the memory side of the cache's DDRAM master. It serves as the standalone memory for small builds and as the memory model for cache verification.

## Interface
- `ADDRBITS`, 24: the command address is `ADDRBITS+1` bits of 64-bit word address.
- `MEMBITS`, 12: the backing RAM is 2^MEMBITS x 64 bits. The RAM index is `ADDR[MEMBITS-1:0]`; upper address bits alias.
- `RD_LATENCY`, 4: cycles from the read-accept edge to the first `DOUT_READY` beat. Legal range is 2..15.
- `CLK` in 1: the single clock.
- `RESET` in 1: asynchronous, active-high reset.
- `STALL` in 1: forces `BUSY` high while the block is in IDLE or WRBURST (test throttle; tie to 0 in builds).
- `DDRAM_ADDR` in ADDRBITS+1: 64-bit word address of the command.
- `DDRAM_BURSTCNT` in 8: beats in the burst. A value of 0 is treated as 1.
- `DDRAM_RD` in 1: read request.
- `DDRAM_WE` in 1: write request / write beat valid.
- `DDRAM_DIN` in 64: write data.
- `DDRAM_BE` in 8: byte enables; bit n gates byte n of `DDRAM_DIN`.
- `DDRAM_DOUT` out 64: read data.
- `DDRAM_DOUT_READY` out 1: read beat valid, 1 cycle per beat.
- `DDRAM_BUSY` out 1: the command or beat presented this cycle is not accepted.

## Operation
- Acceptance rule: a command or beat is taken at a rising edge where (`DDRAM_RD` or `DDRAM_WE`) = 1 and `DDRAM_BUSY` = 0. The master holds its signals while `BUSY` is high.
- `DDRAM_BUSY` = `RESET` | (`STALL` & state ∈ {IDLE, WRBURST}) | (state ∈ {RDWAIT, RDBURST}). It is combinational.
- States: IDLE, WRBURST, RDWAIT, RDBURST.
- **IDLE, `WE` accepted:** beat 0 is written to `mem[ADDR]` with byte enables `BE`. Latch `waddr = ADDR+1` and `wleft = N-1`. If N>1 go to WRBURST, else stay in IDLE.
- **IDLE, `RD` and `WE` both high:** the write is accepted and the read is ignored (protocol violation; no read is started).
- **IDLE, `RD` accepted:** latch `raddr = ADDR`, `rleft = N`, and `lat = RD_LATENCY-1`. Go to RDWAIT.
- **WRBURST:** each accepted `WE` beat writes `mem[waddr]` with `BE`, then `waddr` increments and `wleft` decrements. Cycles with `WE` low are gaps and are legal. When `wleft` reaches 0 after a beat, go to IDLE. `RD` is ignored in this state.
- **RDWAIT:** `lat` counts down. The RAM read of `raddr` is issued one cycle before the first beat is due. Go to RDBURST so the first beat lands exactly `RD_LATENCY` edges after accept.
- **RDBURST:** one beat per cycle with no gaps. `DOUT_READY` = 1 and `DOUT = mem[raddr]`, then `raddr` increments and `rleft` decrements. After the last beat, go to IDLE.
- Address arithmetic is modulo 2^MEMBITS: a burst starting at index 2^MEMBITS-1 continues at index 0. There is no line-wrap (the cache issues line-aligned bursts).
- Reads return data as of the read-accept edge plus any writes committed before each beat's RAM read. No writes can occur during a read, because `BUSY` is high.
- Reset (asynchronous, any state, including mid-burst): state = IDLE, `DOUT` = 0, `DOUT_READY` = 0, all counters = 0, `BUSY` = 1 while `RESET` is high. Memory contents are preserved. Any pending burst is discarded.

## Timing
- Read: accept at edge k. `DOUT_READY` is high after edges k+RD_LATENCY .. k+RD_LATENCY+N-1. `BUSY` is high from k+1 through the last-beat cycle. The next command can be accepted at edge k+RD_LATENCY+N.
- Write: each beat commits at its accept edge. A read accepted at the next edge returns the new data.
- Write burst of N beats without gaps: N edges. The next command can be accepted at the edge after the last beat.
- `DOUT` holds its last value when `DOUT_READY` = 0.
- There is no combinational path from `DDRAM_*` inputs to `DDRAM_DOUT`/`DOUT_READY`. `BUSY` depends combinationally only on `RESET`, `STALL`, and the state.

## Test plan
- **Partial write then read:** write `ADDR=0x10`, `DIN=0x1122334455667788`, `BE=0xFF`. Then write the same address with `DIN=0xAAAAAAAAAAAAAAAA`, `BE=0x0F`. Then read with N=1. Required: one beat `0x11223344AAAAAAAA`, exactly 4 edges after accept.
- **Line read:** preload 0x100..0x107 with value = index. Read `ADDR=0x100`, N=8. Required: 8 consecutive beats 0x100..0x107; `BUSY` high for 11 cycles; a new `RD` accepted on the 12th edge.
- **Stall:** assert `STALL` for 5 cycles while `RD` is pending. Required: no acceptance, `DOUT_READY` stays 0; accept on the first edge after `STALL` drops; data correct.
- **Burst write with gaps:** write N=4 at `0x20` with one idle cycle between beats 2 and 3. Then read N=4. Required: all 4 words correct, and no spurious write to 0x24.
- **Wrap:** with MEMBITS=12, read `ADDR=0xFFE`, N=4. Required: beats `mem[0xFFE]`, `mem[0xFFF]`, `mem[0x000]`, `mem[0x001]`.
- **Reset mid-burst:** assert `RESET` after beat 3 of an 8-beat read. Required: `DOUT_READY` is 0 immediately, `BUSY` is 1 during reset and 0 after release, and a re-read returns unchanged memory.
